// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative HI/LO multiply/divide unit. Performs MULT, MULTU,
//               DIV and DIVU over WIDTH iterations (one shift-add or
//               restoring shift-subtract step per clock). The result is kept
//               in the architectural HI/LO registers, which can also be
//               written directly via mthi/mtlo.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, op         - launch request (IDLE only), operation
//                                   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               operand_a/b       - rs/rt values; operand_a is MTHI/MTLO data
//               mthi, mtlo        - direct HI/LO writes (IDLE only)
//               busy              - unit is not IDLE
//               done              - one-cycle commit pulse
//               div_by_zero       - pulses with done on divide by zero
//               hi, lo            - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;          // negate product / quotient
  logic               rem_neg_q, rem_neg_d;  // remainder takes dividend sign
  logic               zero_q, zero_d;        // divisor was zero
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting in / quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & operand_a[WIDTH-1];
    b_neg     = is_signed & operand_b[WIDTH-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? b_mag_q : {WIDTH{1'b0}})};
    // Shifted remainder is WIDTH+1 bits; a clear MSB means it covers b.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_q};

    prod_fix  = neg_q ? -acc_q : acc_q;
    quot_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    zero_d    = zero_q;
    b_mag_d   = b_mag_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // start takes priority; a simultaneous mthi/mtlo is dropped
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          zero_d    = (operand_b == {WIDTH{1'b0}});
          b_mag_d   = b_mag;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          count_d   = {CW{1'b0}};
          state_d   = RUN;
        end else begin
          if (mthi) hi_d = operand_a;
          if (mtlo) lo_d = operand_a;
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH])
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (is_div_q) begin
          if (zero_q) begin
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= {CW{1'b0}};
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      b_mag_q   <= {WIDTH{1'b0}};
      acc_q     <= {2*WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      zero_q    <= zero_d;
      b_mag_q   <= b_mag_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Expected HI/LO values
//               come from a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: updates exp_hi/exp_lo, reports divide by zero.
  task automatic model(input logic [1:0] mop, input logic [31:0] a,
                       input logic [31:0] b, output logic dbz);
    longint sa, sb, q, r, p;
    logic [63:0] up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    case (mop)
      2'b00: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      2'b10: begin
        if (b == 0) dbz = 1'b1;
        else begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      end
      default: begin
        if (b == 0) dbz = 1'b1;
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the launch edge,
  // with operands scrambled to exercise operand isolation.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  // Waits (bounded) for done; returns at the negedge where done is seen.
  task automatic wait_result(output int busy_cnt, output int done_cnt, output logic dbz_seen);
    busy_cnt = 0; done_cnt = 0; dbz_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; dbz_seen = div_by_zero; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (hi !== 32'd0)         begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0)         begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult_latency;
    int bc, dc; logic dz, edz;
    model(2'b00, 32'hFFFFFFFD, 32'd7, edz);
    issue(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_result(bc, dc, dz);
    total++; if (bc !== 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
    total++; if (dc !== 1)  begin bad++; $display("FAIL mult_done got=%0d exp=1", dc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_at_done got=%b exp=0", busy); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL mult_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL mult_lo got=%h exp=%h", lo, exp_lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_single got=%b exp=0", done); end
  endtask

  task automatic test_arith;
    logic [1:0]  ops [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] as  [3] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100};
    logic [31:0] bs  [3] = '{32'hFFFFFFFF, 32'd2, 32'd7};
    int bc, dc; logic dz, edz;
    for (int i = 0; i < 3; i++) begin
      model(ops[i], as[i], bs[i], edz);
      issue(ops[i], as[i], bs[i]);
      wait_result(bc, dc, dz);
      total++; if (dc !== 1) begin bad++; $display("FAIL arith%0d_done got=%0d exp=1", i, dc); end
      total++; if (hi !== exp_hi) begin bad++; $display("FAIL arith%0d_hi got=%h exp=%h", i, hi, exp_hi); end
      total++; if (lo !== exp_lo) begin bad++; $display("FAIL arith%0d_lo got=%h exp=%h", i, lo, exp_lo); end
      @(negedge clk);
    end
  endtask

  task automatic test_mthi_div_zero;
    int bc, dc; logic dz, edz;
    mthi = 1'b1; operand_a = 32'h1234;
    @(negedge clk);
    mthi = 1'b0; exp_hi = 32'h1234;
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL mthi_hi got=%h exp=%h", hi, exp_hi); end
    model(2'b11, 32'd100, 32'd0, edz);
    issue(2'b11, 32'd100, 32'd0);
    wait_result(bc, dc, dz);
    total++; if (bc !== 33) begin bad++; $display("FAIL dbz_busy_cycles got=%0d exp=33", bc); end
    total++; if (dc !== 1) begin bad++; $display("FAIL dbz_done got=%0d exp=1", dc); end
    total++; if (dz !== edz) begin bad++; $display("FAIL dbz_flag got=%b exp=%b", dz, edz); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL dbz_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL dbz_lo got=%h exp=%h", lo, exp_lo); end
    @(negedge clk);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_single got=%b exp=0", div_by_zero); end
    model(2'b10, 32'h80000000, 32'hFFFFFFFF, edz);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_result(bc, dc, dz);
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL ovf_dbz got=%b exp=0", dz); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL ovf_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL ovf_lo got=%h exp=%h", lo, exp_lo); end
    @(negedge clk);
  endtask

  task automatic test_mt_combo;
    int bc, dc; logic dz, edz;
    mthi = 1'b1; mtlo = 1'b1; operand_a = 32'hCAFEF00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; exp_hi = 32'hCAFEF00D; exp_lo = 32'hCAFEF00D;
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL mtboth_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL mtboth_lo got=%h exp=%h", lo, exp_lo); end
    // start with mthi in the same cycle: the write must be dropped
    model(2'b01, 32'd2, 32'd3, edz);
    mthi = 1'b1;
    issue(2'b01, 32'd2, 32'd3);
    mthi = 1'b0;
    wait_result(bc, dc, dz);
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL startwin_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL startwin_lo got=%h exp=%h", lo, exp_lo); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int bc, dc; logic dz, edz;
    model(2'b00, 32'd5, 32'd6, edz);
    issue(2'b00, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = 2'b11; operand_a = 32'd99; operand_b = 32'd77;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_result(bc, dc, dz);
    total++; if (dc !== 1) begin bad++; $display("FAIL iso_done got=%0d exp=1", dc); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL iso_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL iso_lo got=%h exp=%h", lo, exp_lo); end
    // launch in the cycle done is high
    model(2'b01, 32'd3, 32'd4, edz);
    issue(2'b01, 32'd3, 32'd4);
    wait_result(bc, dc, dz);
    total++; if (bc !== 33) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=33", bc); end
    total++; if (dc !== 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", dc); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL b2b_lo got=%h exp=%h", lo, exp_lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int bc, dc, stray; logic dz, edz;
    issue(2'b10, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_hi = 32'd0; exp_lo = 32'd0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) stray++;
      @(negedge clk);
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", stray); end
    model(2'b11, 32'd9, 32'd3, edz);
    issue(2'b11, 32'd9, 32'd3);
    wait_result(bc, dc, dz);
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL rstmid_after_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL rstmid_after_lo got=%h exp=%h", lo, exp_lo); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int bc, dc; logic dz, edz;
    logic [1:0] o; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      model(o, a, b, edz);
      issue(o, a, b);
      wait_result(bc, dc, dz);
      total++; if (dc !== 1) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=1", i, dc); end
      total++; if (dz !== edz) begin bad++; $display("FAIL rnd%0d_dbz op=%0d a=%h b=%h got=%b exp=%b", i, o, a, b, dz, edz); end
      total++; if (hi !== exp_hi) begin bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, hi, exp_hi); end
      total++; if (lo !== exp_lo) begin bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, lo, exp_lo); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_mult_latency;
    test_arith;
    test_mthi_div_zero;
    test_mt_combo;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
